// File: rtl/brlshft_pkg.sv
// Shared definitions for the barrel-shift restore datapath.
// Widths, FSM state encoding and direction constants.
package brlshft_pkg;

    localparam int BRL_WIDTH = 4;
    localparam int BRL_SHW   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/brlshft_step.sv
// One-position inverse of a barrel shift/rotate.
// Shift undo marks the vacated position as lost.
module brlshft_step
    import brlshft_pkg::*;
#(
    parameter int WIDTH = BRL_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] lost,
    input  logic             l_r,
    input  logic             rot,
    output logic [WIDTH-1:0] data_nxt,
    output logic [WIDTH-1:0] lost_nxt
);

    // Undo one position of the forward op in the opposite direction
    always_comb begin
        data_nxt = data;
        lost_nxt = lost;
        unique case (1'b1)
            (l_r == DIR_LEFT) && rot: begin
                data_nxt = {data[0], data[WIDTH-1:1]};
            end
            (l_r == DIR_RIGHT) && rot: begin
                data_nxt = {data[WIDTH-2:0], data[WIDTH-1]};
            end
            (l_r == DIR_LEFT) && !rot: begin
                data_nxt = {1'b0, data[WIDTH-1:1]};
                lost_nxt = {1'b1, lost[WIDTH-1:1]};
            end
            default: begin
                data_nxt = {data[WIDTH-2:0], 1'b0};
                lost_nxt = {lost[WIDTH-2:0], 1'b1};
            end
        endcase
    end

endmodule

// File: rtl/brlshft_unshift.sv
// Iterative restore of a barrel-shifted word, one position per clock.
// Positions destroyed by a logical shift are reported in lost.
module brlshft_unshift
    import brlshft_pkg::*;
#(
    parameter int WIDTH = BRL_WIDTH,
    parameter int SHW   = BRL_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             l_r,
    input  logic             rot,
    input  logic [SHW-1:0]   sv,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] lost
);

    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_ZERO = '0;

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] lost_q;
    logic [SHW-1:0]   cnt_q;
    logic             lr_q;
    logic             rot_q;
    logic [WIDTH-1:0] data_step;
    logic [WIDTH-1:0] lost_step;
    logic             accept;

    assign accept = in_valid && (state_q == IDLE);

    brlshft_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data     (data_q),
        .lost     (lost_q),
        .l_r      (lr_q),
        .rot      (rot_q),
        .data_nxt (data_step),
        .lost_nxt (lost_step)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and state-decoded handshake outputs
    always_comb begin
        state_nxt = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the request, then walk it back one position per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            lost_q <= '0;
            cnt_q  <= '0;
            lr_q   <= 1'b0;
            rot_q  <= 1'b0;
        end else if (accept) begin
            data_q <= din;
            lost_q <= '0;
            cnt_q  <= sv;
            lr_q   <= l_r;
            rot_q  <= rot;
        end else if (state_q == SHIFT && cnt_q != CNT_ZERO) begin
            data_q <= data_step;
            lost_q <= lost_step;
            cnt_q  <= cnt_q - CNT_ONE;
        end
    end

    assign dout = data_q;
    assign lost = lost_q;

endmodule

// File: doc/brlshft_unshift.md
Name: brlshft_unshift

Overview:
Iterative inverse of the 4-bit barrel shifter. It takes a shifted or rotated word plus the control used to produce it (direction, rotate, shift amount). It reconstructs the original word one bit position per clock. Bit positions destroyed by a logical shift are flagged in a lost mask. It sits downstream of brlshft as the decode/restore end and uses a valid/ready handshake on both sides.

Parameters:
WIDTH, 4, data width in bits
SHW, 2, shift-amount width; must equal clog2(WIDTH)

Ports:
clk        input   1      rising-edge clock
rst        input   1      asynchronous, active-high reset
in_valid   input   1      request valid
in_ready   output  1      block can accept a request (high only in IDLE)
l_r        input   1      forward direction used by brlshft: 1 = left, 0 = right
rot        input   1      forward op: 1 = rotate, 0 = logical shift (zero fill)
sv         input   SHW    forward shift amount, 0..WIDTH-1
din        input   WIDTH  forward-shifted word to be restored
out_valid  output  1      result valid (high only in DONE)
out_ready  input   1      consumer accepts result
dout       output  WIDTH  restored word; lost positions are 0
lost       output  WIDTH  1 = bit position unrecoverable (shift only)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high: state=IDLE, dout=0, lost=0, cnt=0, out_valid=0, in_ready=1.
- States: IDLE, SHIFT, DONE. Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch din into the data register, latch l_r/rot, cnt<=sv, lost<=0. Go to SHIFT.
- SHIFT: in_ready=0, out_valid=0.
  - If cnt==0: go to DONE.
  - Else apply one inverse step and decrement cnt:
    - l_r=1, rot=1: rotate right by 1. lost unchanged.
    - l_r=0, rot=1: rotate left by 1. lost unchanged.
    - l_r=1, rot=0: data <= {0, data[W-1:1]}, lost <= {1, lost[W-1:1]}.
    - l_r=0, rot=0: data <= {data[W-2:0], 0}, lost <= {lost[W-2:0], 1}.
- DONE:
  - out_valid=1. dout and lost are held stable.
  - On out_ready: go to IDLE.
  - No new request is accepted in the same cycle as the result handoff.
- Latency: for an accept at edge E0, out_valid rises after edge E(sv+1). Examples: sv=0 gives 1 cycle; sv=3 gives 4 cycles.
- Throughput: at most one request per sv+3 cycles.
- Invariants:
  - lost always has exactly sv ones, contiguous from the MSB (l_r=1) or from the LSB (l_r=0).
  - dout & lost == 0.
- Input changes while busy: l_r, rot, sv and din are ignored outside the accept cycle. in_valid held high while busy has no effect.
- Backpressure: out_ready low holds DONE indefinitely, with dout, lost and out_valid stable.
- Reset mid-operation (SHIFT or DONE): immediate return to the reset values, and the in-flight request is discarded.
- Any SHW-bit value of sv is legal when WIDTH = 2^SHW.

Decomposition:
- Shared package brlshft_pkg:
  - BRL_WIDTH default (4) and BRL_SHW default (2).
  - State enum: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - Direction constants: DIR_LEFT=1, DIR_RIGHT=0.
- One sub-module, brlshft_step: combinational single-position inverse step.
  - Inputs: data, lost, l_r, rot.
  - Outputs: next data, next lost.
  - Instantiated once inside the FSM datapath.

Test Plan:
1. din=1010, l_r=1, rot=0, sv=1, out_ready=1 -> dout=0101, lost=1000; out_valid after 2nd edge post-accept, then back to IDLE.
2. din=0111, l_r=0, rot=1, sv=2 -> dout=1101, lost=0000; out_valid after 3rd edge.
3. din=0001, l_r=0, rot=0, sv=3 -> dout=1000, lost=0111. Also din=1101, l_r=1, rot=1, sv=0 -> dout=1101, lost=0000 after 1st edge.
4. Exhaustive round-trip: for all 16 values x, both directions, both rot values and all 4 sv values, feed brlshft output as din. Require (dout | (x & lost)) == x and dout & lost == 0.
5. Backpressure: finish scenario 1 with out_ready low for 5 cycles -> dout=0101, lost=1000 stable, out_valid=1, in_ready=0 throughout. in_valid held high is not accepted until one cycle after the out_ready handshake.
6. Reset mid-SHIFT: accept sv=3, assert rst one edge later without waiting for clk -> out_valid=0, dout=0000, lost=0000, in_ready=1 immediately. After release, a new request completes normally.
